// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   N_DIG_DEF : default number of BCD digits produced
//   DIGIT_W   : width of one BCD digit
//   MAX_VAL   : largest binary value representable in N_DIG_DEF digits
//   SAT_DIGIT : digit value used to fill a saturated result
//   b2b_state_t : converter FSM states
package bcd_pkg;

  localparam int           N_DIG_DEF = 8;
  localparam int           DIGIT_W   = 4;
  localparam logic [31:0]  MAX_VAL   = 32'd99_999_999;
  localparam logic [3:0]   SAT_DIGIT = 4'h9;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } b2b_state_t;

endpackage

// File: rtl/dabble_adjust.sv
// One digit of the double-dabble correction step: a BCD digit of 5 or more
// gets 3 added so that the following left shift carries correctly into the
// next decimal digit.
//   d : scratch digit before the shift
//   q : corrected digit
module dabble_adjust
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d,
  output logic [DIGIT_W-1:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// A conversion takes N_BIN shift cycles plus one cycle to publish the result.
// Inputs above 10^N_DIG-1 saturate to all nines and raise overflow.
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bin      : binary operand, sampled when start is accepted
//   start    : conversion request, accepted only while idle
//   bcd      : packed BCD result, units digit in [3:0], held until next done
//   busy     : conversion in progress (state other than IDLE)
//   done     : one-cycle pulse marking the first cycle of a new result
//   overflow : result was saturated, held alongside bcd
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int N_BIN = 32,
  parameter int N_DIG = N_DIG_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_BIN-1:0]         bin,
  input  logic                     start,
  output logic [DIGIT_W*N_DIG-1:0] bcd,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);

  localparam int BCD_W  = DIGIT_W * N_DIG;
  localparam int ITER_W = $clog2(N_BIN);
  localparam logic [N_BIN-1:0] LIMIT = N_BIN'(MAX_VAL);

  b2b_state_t        state, next_state;
  logic [N_BIN-1:0]  shift_reg;
  logic [BCD_W-1:0]  scratch;
  logic [BCD_W-1:0]  adjusted;
  logic [ITER_W-1:0] iter;
  logic              ovf_pend;

  // Per-digit correction applied to the scratch word before every shift.
  for (genvar g = 0; g < N_DIG; g++) begin : g_adj
    dabble_adjust u_adj (
      .d (scratch [g*DIGIT_W +: DIGIT_W]),
      .q (adjusted[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves next_state unassigned,
    // which would otherwise infer a latch.
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = SHIFT;
      SHIFT:   if (iter == '0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: the scratch/shift registers are reset too, so an abandoned
  // conversion leaves no stale partial result behind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg <= '0;
      scratch   <= '0;
      iter      <= '0;
      ovf_pend  <= 1'b0;
      bcd       <= '0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= bin;
            scratch   <= '0;
            iter      <= ITER_W'(N_BIN - 1);
            ovf_pend  <= (bin > LIMIT);
          end
        end
        SHIFT: begin
          // Bits leaving the top digit only occur for overflow inputs,
          // whose result is replaced by the saturation pattern anyway.
          scratch   <= {adjusted[BCD_W-2:0], shift_reg[N_BIN-1]};
          shift_reg <= {shift_reg[N_BIN-2:0], 1'b0};
          if (iter != '0) iter <= iter - ITER_W'(1);
        end
        DONE: begin
          bcd      <= ovf_pend ? {N_DIG{SAT_DIGIT}} : scratch;
          overflow <= ovf_pend;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed test bench for bin_to_bcd_seq: reset state, single conversions
// with hand-computed results, upper-boundary and overflow saturation, start
// held high across back-to-back runs, reset mid-conversion, and a short
// sweep checked against a decimal-division reference.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] bin = '0;
  logic        start = 1'b0;
  logic [31:0] bcd;
  logic        busy, done, overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bin      (bin),
    .start    (start),
    .bcd      (bcd),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference: repeated division by ten, saturating above eight digits.
  function automatic logic [31:0] ref_bcd(input logic [31:0] v);
    logic [31:0] r = '0;
    logic [31:0] x = v;
    if (v > 32'd99_999_999) return 32'h9999_9999;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // One conversion: start for one cycle, then watch busy/done at negedges.
  // cyc counts negedges after the accepting edge, starting at 0.
  task automatic run_conv(input string tag, input logic [31:0] b,
                          input logic [31:0] exp_bcd, input logic exp_ovf);
    int cyc = 0;
    int busy_cnt = 0;
    @(negedge clk);
    bin   = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!done && cyc < 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    check({tag, ":latency"}, cyc, 33);
    check({tag, ":busy_cycles"}, busy_cnt, 33);
    check({tag, ":bcd"}, bcd, exp_bcd);
    check({tag, ":ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
    check({tag, ":busy_at_done"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    check({tag, ":done_single"}, {31'd0, done}, 32'd0);
    check({tag, ":bcd_held"}, bcd, exp_bcd);
  endtask

  initial begin
    int cyc;
    int done_cnt;
    logic [31:0] v;

    // Reset state
    #12;
    check("rst:bcd", bcd, 32'h0);
    check("rst:busy", {31'd0, busy}, 32'd0);
    check("rst:done", {31'd0, done}, 32'd0);
    check("rst:ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed conversions
    run_conv("zero",  32'd0,          32'h0000_0000, 1'b0);
    run_conv("mixed", 32'd12_345_678, 32'h1234_5678, 1'b0);
    run_conv("max",   32'd99_999_999, 32'h9999_9999, 1'b0);
    run_conv("one",   32'd1,          32'h0000_0001, 1'b0);

    // start held high: bin change mid-run ignored, second run takes new bin
    @(negedge clk);
    bin   = 32'd12_345_678;
    start = 1'b1;
    cyc = 0;
    done_cnt = 0;
    @(negedge clk);
    while (cyc < 33) begin
      if (cyc == 5) bin = 32'd42;
      @(negedge clk);
      cyc++;
      if (done) done_cnt++;
    end
    check("hold:first_done", {31'd0, done}, 32'd1);
    check("hold:first_bcd", bcd, 32'h1234_5678);
    while (!(done && cyc > 33) && cyc < 150) begin
      @(negedge clk);
      cyc++;
      if (done) done_cnt++;
    end
    start = 1'b0;
    check("hold:second_latency", cyc, 67);
    check("hold:second_bcd", bcd, 32'h0000_0042);
    check("hold:done_pulses", done_cnt, 2);

    // Overflow saturation
    run_conv("ovf_lo",  32'd100_000_000, 32'h9999_9999, 1'b1);
    run_conv("ovf_max", 32'hFFFF_FFFF,   32'h9999_9999, 1'b1);

    // Reset during SHIFT cycle 10
    @(negedge clk);
    bin   = 32'd555;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst:bcd", bcd, 32'h0);
    check("midrst:busy", {31'd0, busy}, 32'd0);
    check("midrst:done", {31'd0, done}, 32'd0);
    check("midrst:ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("midrst:no_done", done_cnt, 0);
    run_conv("after_rst", 32'd555, 32'h0000_0555, 1'b0);

    // Short sweep against the reference
    for (int i = 0; i < 120; i++) begin
      v = (i % 4 == 0) ? $urandom() : $urandom_range(99_999_999, 0);
      run_conv($sformatf("sweep%0d", i), v, ref_bcd(v), v > 32'd99_999_999);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
